// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with push FIFO, runtime baud divisor and frame format
// Define UART_TX_BREAK_EN to add the tx_break input and break/mark-after-break generation.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 125_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic [1:0]                  cfg_data_bits,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                        tx_break,
`endif
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        tx_busy,
    output logic                        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (CLK_FREQ / BAUD_RATE < 2) begin : g_bad_baud
        $error("CLK_FREQ/BAUD_RATE must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_TX_BREAK_EN
        , S_BREAK,
        S_MAB
`endif
    } state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] f_div;
    logic [7:0]       shreg;
    logic [2:0]       bit_idx;
    logic [2:0]       f_last;
    logic             f_par_en;
    logic             f_par_bit;
    logic             f_stop2;
    logic             stop_idx;

    logic [DIV_W-1:0] div_eff;
    logic [7:0]       data_mask;
    logic [7:0]       head_masked;
    logic             head_par;
    logic             bit_end;
    logic             stop_end;
    logic             can_start;
    logic             brk_req;

    assign div_eff     = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
    assign data_mask   = 8'hFF >> (2'd3 - cfg_data_bits);
    assign head_masked = mem[rd_ptr] & data_mask;

    always_comb begin
        head_par = 1'b1;
        case (cfg_parity)
            2'b01:   head_par = ~^head_masked;
            2'b10:   head_par = ^head_masked;
            default: head_par = 1'b1;
        endcase
    end

    assign bit_end   = (cnt == f_div - DIV_W'(1));
    assign stop_end  = (state == S_STOP) && bit_end && (stop_idx == f_stop2);
    assign can_start = (state == S_IDLE) || stop_end;

`ifdef UART_TX_BREAK_EN
    assign brk_req = tx_break;
`else
    assign brk_req = 1'b0;
`endif

    // A pending break outranks queued data whenever a new frame could begin.
    assign pop        = can_start && !brk_req && (count != '0);
    assign push       = tx_valid && tx_ready;
    assign tx_ready   = (count < CW'(FIFO_DEPTH));
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            f_div     <= DIV_W'(2);
            shreg     <= '0;
            bit_idx   <= '0;
            f_last    <= 3'd7;
            f_par_en  <= 1'b0;
            f_par_bit <= 1'b0;
            f_stop2   <= 1'b0;
            stop_idx  <= 1'b0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
        end else if (pop) begin
            // Frame format is captured here so later cfg changes only affect the next frame.
            state     <= S_START;
            cnt       <= '0;
            f_div     <= div_eff;
            shreg     <= head_masked;
            bit_idx   <= '0;
            f_last    <= 3'd4 + {1'b0, cfg_data_bits};
            f_par_en  <= (cfg_parity != 2'b00);
            f_par_bit <= head_par;
            f_stop2   <= cfg_stop2;
            stop_idx  <= 1'b0;
            tx        <= 1'b0;
            tx_busy   <= 1'b1;
`ifdef UART_TX_BREAK_EN
        end else if (can_start && brk_req) begin
            state   <= S_BREAK;
            cnt     <= '0;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
`endif
        end else begin
            cnt <= bit_end ? '0 : cnt + DIV_W'(1);
            case (state)
                S_START: begin
                    if (bit_end) begin
                        state <= S_DATA;
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == f_last) begin
                            if (f_par_en) begin
                                state <= S_PARITY;
                                tx    <= f_par_bit;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (stop_idx == f_stop2) begin
                            state   <= S_IDLE;
                            tx_busy <= 1'b0;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                S_BREAK: begin
                    cnt <= '0;
                    if (!tx_break) begin
                        state <= S_MAB;
                        f_div <= div_eff;
                        tx    <= 1'b1;
                    end
                end
                S_MAB: begin
                    if (bit_end) begin
                        state   <= S_IDLE;
                        tx_busy <= 1'b0;
                    end
                end
`endif
                default: begin
                    cnt     <= '0;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo against a frame-level bit model
module tb_uart_tx_fifo;
    localparam int DIV_W = 16;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [DIV_W-1:0] cfg_div;
    logic [1:0]       cfg_data_bits;
    logic [1:0]       cfg_parity;
    logic             cfg_stop2;
    logic [CW-1:0]    fifo_count;
    logic             tx_busy;
    logic             tx;

    int checks   = 0;
    int failures = 0;
    bit exp_bits[$];

    uart_tx_fifo #(
        .CLK_FREQ(125_000_000),
        .BAUD_RATE(115200),
        .DIV_W(DIV_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .cfg_div(cfg_div),
        .cfg_data_bits(cfg_data_bits),
        .cfg_parity(cfg_parity),
        .cfg_stop2(cfg_stop2),
        .fifo_count(fifo_count),
        .tx_busy(tx_busy),
        .tx(tx)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line levels of one frame, one entry per bit period.
    task automatic add_frame(input logic [7:0] d, input int db, input int par, input bit s2);
        int nb;
        int ones;
        nb   = 5 + db;
        ones = 0;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            exp_bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par == 1) exp_bits.push_back((ones % 2) == 0);
        else if (par == 2) exp_bits.push_back((ones % 2) == 1);
        else if (par == 3) exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b1);
        if (s2) exp_bits.push_back(1'b1);
    endtask

    task automatic set_cfg(input int div, input int db, input int par, input bit s2);
        cfg_div       = DIV_W'(div);
        cfg_data_bits = 2'(db);
        cfg_parity    = 2'(par);
        cfg_stop2     = s2;
    endtask

    task automatic check_frame(input logic [7:0] d, input int div, input int db, input int par,
                               input bit s2, input int chg_at, input int chg_div);
        int ediv;
        int len;
        ediv = (div < 2) ? 2 : div;
        exp_bits.delete();
        add_frame(d, db, par, s2);
        len = ediv * exp_bits.size();
        set_cfg(div, db, par, s2);
        tx_data  = d;
        tx_valid = 1'b1;
        cyc();
        tx_valid = 1'b0;
        chk("count_after_push", fifo_count, 1);
        chk("tx_before_start", tx, 1);
        cyc();
        chk("count_after_pop", fifo_count, 0);
        for (int k = 0; k < len; k++) begin
            if (k == chg_at) cfg_div = DIV_W'(chg_div);
            chk("frame_tx", tx, exp_bits[k / ediv]);
            chk("frame_busy", tx_busy, 1);
            cyc();
        end
        chk("busy_after_frame", tx_busy, 0);
        chk("tx_idle_after_frame", tx, 1);
    endtask

    task automatic burst(input int n, input int div, input int db, input int par, input bit s2,
                         input bit rnd, input bit expect_full);
        logic [7:0] data [$];
        int ediv;
        int len;
        bit saw_full;
        ediv = (div < 2) ? 2 : div;
        exp_bits.delete();
        for (int i = 0; i < n; i++) begin
            data.push_back(rnd ? 8'($urandom) : 8'(i));
            add_frame(data[i], db, par, s2);
        end
        len = ediv * exp_bits.size();
        set_cfg(div, db, par, s2);
        saw_full = 1'b0;
        fork
            begin : pusher
                int idx;
                bit acc;
                idx      = 0;
                tx_valid = 1'b1;
                tx_data  = data[0];
                for (int guard = 0; guard < 4000 && idx < n; guard++) begin
                    chk("ready_vs_count", tx_ready, (fifo_count < CW'(DEPTH)));
                    if (fifo_count == CW'(DEPTH)) saw_full = 1'b1;
                    acc = tx_ready;
                    cyc();
                    if (acc) begin
                        idx++;
                        if (idx < n) tx_data = data[idx];
                    end
                end
                tx_valid = 1'b0;
                chk("burst_all_pushed", idx, n);
            end
            begin : line_checker
                cyc();
                cyc();
                for (int k = 0; k < len; k++) begin
                    chk("burst_tx", tx, exp_bits[k / ediv]);
                    cyc();
                end
            end
        join
        chk("burst_busy_end", tx_busy, 0);
        chk("burst_count_end", fifo_count, 0);
        if (expect_full) chk("burst_saw_full", saw_full, 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        set_cfg(4, 3, 0, 1'b0);
        cyc();
        cyc();
        chk("reset_tx", tx, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_ready", tx_ready, 1);
        chk("reset_count", fifo_count, 0);
        rst_n = 1'b1;
        cyc();

        check_frame(8'hA5, 4, 3, 0, 1'b0, -1, 0);
        check_frame(8'h41, 3, 2, 2, 1'b1, -1, 0);
        check_frame(8'h41, 3, 2, 1, 1'b1, -1, 0);

        burst(20, 2, 3, 0, 1'b0, 1'b0, 1'b1);

        check_frame(8'h5A, 4, 3, 0, 1'b0, 10, 8);
        check_frame(8'hC3, 8, 3, 0, 1'b0, -1, 0);
        check_frame(8'h96, 1, 3, 0, 1'b0, -1, 0);
        check_frame(8'h3C, 0, 1, 3, 1'b0, -1, 0);

        // Reset while data bit 3 of the first of five queued bytes is on the line.
        set_cfg(4, 3, 0, 1'b0);
        exp_bits.delete();
        add_frame(8'h37, 3, 0, 1'b0);
        tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_data = 8'h37 + 8'(i);
            cyc();
        end
        tx_valid = 1'b0;
        for (int i = 5; i < 19; i++) cyc();
        chk("pre_reset_bit", tx, exp_bits[(19 - 2) / 4]);
        chk("pre_reset_count", fifo_count, 4);
        rst_n = 1'b0;
        #1;
        chk("async_reset_tx", tx, 1);
        chk("async_reset_busy", tx_busy, 0);
        chk("async_reset_count", fifo_count, 0);
        chk("async_reset_ready", tx_ready, 1);
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            chk("post_reset_quiet", {tx, tx_busy, fifo_count}, {1'b1, 1'b0, CW'(0)});
            cyc();
        end
        check_frame(8'hE7, 2, 0, 2, 1'b1, -1, 0);

        for (int r = 0; r < 12; r++) begin
            check_frame(8'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, 0);
        end
        for (int r = 0; r < 3; r++) begin
            burst(int'($urandom_range(2, 8)), int'($urandom_range(2, 4)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. It adds a transmit FIFO with a valid/ready push interface and a runtime baud divisor. Frame format is runtime-configurable: 5–8 data bits, none/odd/even/mark parity, and 1 or 2 stop bits. It sits between the host-side byte producer (debug/report path) and the board UART pin.

Parameters:
CLK_FREQ, 125_000_000, system clock frequency in Hz.
BAUD_RATE, 115200, baud rate; recommended cfg_div = CLK_FREQ/BAUD_RATE.
DIV_W, 16, width of the baud divisor.
FIFO_DEPTH, 16, FIFO entries; power of two, ≥2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tx_data  in  8  byte to enqueue
tx_valid  in  1  push request
tx_ready  out  1  FIFO can accept; push occurs when tx_valid && tx_ready
cfg_div  in  DIV_W  clocks per bit; values <2 are treated as 2
cfg_data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
cfg_parity  in  2  00=none, 01=odd, 10=even, 11=mark (always 1)
cfg_stop2  in  1  0=1 stop bit, 1=2 stop bits
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently queued
tx_busy  out  1  a frame is in progress
tx  out  1  serial line; idles high

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: tx=1, tx_busy=0, tx_ready=1, fifo_count=0. The FSM is in IDLE, the FIFO pointers are cleared, and the bit counters are 0.
- Reset mid-frame: tx returns high asynchronously. All queued bytes are discarded.
- FIFO:
  - tx_ready = (fifo_count < FIFO_DEPTH). It is registered/derived from count, with no combinational path from tx_valid.
  - A simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - tx_data bits above the configured data width are ignored on transmit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If the FIFO is non-empty: pop the head byte and latch cfg_div, cfg_data_bits, cfg_parity and cfg_stop2 into frame registers. Go to START and set tx_busy=1.
  - Config changes mid-frame affect only the next frame.
- START: tx=0 for div cycles, then go to DATA.
- DATA:
  - Bits go out LSB first, each held div cycles.
  - After N bits, go to PARITY if parity≠none, else go to STOP.
- PARITY: one bit period.
  - even: XOR of the N data bits.
  - odd: inverse of that XOR.
  - mark: 1.
- STOP: tx=1 for div cycles (2·div cycles if stop2).
- End of the last stop cycle:
  - If the FIFO is non-empty: pop and enter START directly. There is zero idle gap between frames.
  - Else go to IDLE and tx_busy=0 on the next cycle.
- Frame length is exactly div·(1+N+P+S) cycles, where P∈{0,1} and S∈{1,2}.
- Latency: a push accepted in cycle 0 with the FIFO empty and the FSM idle gives tx low from cycle 2.
- Bit counter: counts 0..div-1 per bit; the bit boundary is at div-1. Counter width is DIV_W, with no overflow for any legal div.
- tx is a registered output only (glitch-free).

Optional Feature:
Macro UART_TX_BREAK_EN.
- When defined: adds port tx_break (in, 1).
  - tx_break is sampled only in IDLE or at the end of a stop bit, and takes priority over a non-empty FIFO.
  - While tx_break=1: tx=0, tx_busy=1, and the FIFO is not popped.
  - On deassertion: tx=1 for one full div period (mark-after-break), then normal IDLE/pop behaviour.
  - A break requested mid-frame waits for the frame to complete.
- When undefined: the port does not exist, and tx is low only during start, data and parity bits.

Test Plan:
1. div=4, 8N1, push 0xA5 → tx sequence in 4-cycle bits is 0,1,0,1,0,0,1,0,1,1; frame is 40 cycles; tx_busy drops the cycle after the stop bit ends; first tx low 2 cycles after the push.
2. div=3, 7E2, push 0x41 → data bits 1,0,0,0,0,0,1, parity 0, stop 1,1; frame is 33 cycles. Repeat with odd parity → parity bit 1.
3. div=2, hold tx_valid for 20 bytes 0x00..0x13 → tx_ready deasserts while count=16; all 20 bytes are sent in order; the start bit follows each stop bit with zero gap; fifo_count returns to 0.
4. cfg_div changed 4→8 halfway through a data bit → the current frame keeps 4-cycle bits; the next frame uses 8-cycle bits. cfg_div=1 → 2-cycle bits.
5. Assert rst_n=0 during data bit 3 with 5 bytes queued → tx=1 immediately; after release, fifo_count=0, tx_ready=1, and no residual frame is sent.
6. (UART_TX_BREAK_EN) Assert tx_break for 50 cycles mid-frame at div=4 → the frame completes first, then tx=0 for 50 cycles, then 4 cycles high, then queued bytes resume.
